uart8_transmitter: RTL and testbench

//   8N1 UART transmitter; transmit-side counterpart of the 8-bit UART receiver.

---
 rtl/uart8_transmitter_pkg.sv | 5 +
 rtl/uart8_transmitter_fifo.sv | 39 +++
 rtl/uart8_transmitter.sv | 104 ++++++++++
 tb/tb_uart8_transmitter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart8_transmitter_pkg.sv
// uart8_transmitter_pkg: line states shared by the 8N1 transmitter and its receiver counterpart.
package uart8_transmitter_pkg;
  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} tx_state_t;
  localparam int DATA_BITS_N = 8;
endpackage

// File: rtl/uart8_transmitter_fifo.sv
// uart_tx_fifo: 8-bit synchronous first-word-fall-through FIFO with flush.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;
  assign dout    = mem[rd_ptr];
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart8_transmitter.sv
// uart8_transmitter: FIFO-buffered 8N1 serialiser, each bit held OVERSAMPLE clocks.
module uart8_transmitter
  import uart8_transmitter_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       start,
  input  logic [7:0] in,
  output logic       ready,
  output logic       out,
  output logic       done,
  output logic       busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  tx_state_t     state, state_n;
  logic [CW-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n, dout;
  logic          out_n, busy_n, done_n, pop, full, empty, bit_end;
  assign ready   = rst_n && en && !full;
  assign bit_end = clk_cnt == CW'(OVERSAMPLE - 1);
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(start && ready), .pop(pop), .flush(!en),
    .din(in), .dout(dout), .full(full), .empty(empty)
  );
  always_comb begin
    state_n   = state;
    clk_cnt_n = bit_end ? '0 : clk_cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    out_n     = out;
    busy_n    = busy;
    done_n    = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = dout;
          out_n   = 1'b0;
          busy_n  = 1'b1;
          state_n = START_BIT;
        end
      end
      START_BIT: if (bit_end) begin
        out_n     = shreg[0];
        bit_idx_n = '0;
        state_n   = DATA_BITS;
      end
      DATA_BITS: if (bit_end) begin
        shreg_n   = shreg >> 1;
        bit_idx_n = bit_idx + 3'd1;
        out_n     = (bit_idx == 3'(DATA_BITS_N - 1)) ? 1'b1 : shreg[1];
        state_n   = (bit_idx == 3'(DATA_BITS_N - 1)) ? STOP_BIT : DATA_BITS;
      end
      STOP_BIT: if (bit_end) begin
        done_n = 1'b1;
        // chain straight into the next start bit so queued bytes leave no idle gap
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = dout;
          out_n   = 1'b0;
          state_n = START_BIT;
        end else begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!en) begin
      state_n   = IDLE;
      clk_cnt_n = '0;
      out_n     = 1'b1;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      pop       = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      out     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      out     <= out_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end
endmodule

// File: tb/tb_uart8_transmitter.sv
// tb_uart8_transmitter: checks line waveform, ready, busy and done against a frame-queue model.
module tb_uart8_transmitter;
  localparam int OS = 16;
  localparam int D  = 4;
  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, start = 1'b0;
  logic [7:0] in = '0;
  logic       ready, out, done, busy, ready_s;
  uart8_transmitter #(.OVERSAMPLE(OS), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .in(in),
    .ready(ready), .out(out), .done(done), .busy(busy)
  );
  always #5 clk = ~clk;

  typedef struct {
    bit r, e, s;
    byte unsigned d;
    bit x_ready, x_out, x_busy, x_done;
  } vec_t;

  int n_vec = 0, n_err = 0, cyc = 0;
  byte unsigned mq[$], rxq[$], sent[$];
  bit lq[$];
  bit m_act = 0, m_out = 1, m_busy = 0, m_done = 0;
  int busy_n = 0, done_n = 0, done_cyc = 0, done_gap = 0, fall_cyc = 0, rx_t = -1;
  byte unsigned rx_b;

  task automatic chk(string nm, logic a, logic e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, a, e);
    end
  endtask

  task automatic chk_n(string nm, int a, int e);
    n_vec++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, a, e);
    end
  endtask

  function automatic bit m_ready();
    return rst_n && en && (mq.size() < D);
  endfunction

  // one clock: drive at negedge, check ready, advance model at posedge, check outputs at next negedge
  task automatic step(bit r, bit e, bit s, byte unsigned d);
    bit push;
    byte unsigned b;
    rst_n = r; en = e; start = s; in = d;
    #1;
    ready_s = ready;
    chk("ready", ready, m_ready());
    push = s && m_ready();
    @(posedge clk);
    cyc++;
    if (!r || !e) begin
      mq.delete(); lq.delete();
      m_act = 0; m_out = 1; m_busy = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (lq.size() == 0) begin
        m_done = m_act;
        m_act  = 0;
        if (mq.size() > 0) begin
          b = mq.pop_front();
          m_act = 1;
          repeat (OS) lq.push_back(1'b0);
          for (int i = 0; i < 8; i++) repeat (OS) lq.push_back(b[i]);
          repeat (OS) lq.push_back(1'b1);
        end
      end
      if (m_act) begin m_out = lq.pop_front(); m_busy = 1; end
      else begin m_out = 1; m_busy = 0; end
      if (push) begin mq.push_back(d); sent.push_back(d); end
    end
    @(negedge clk);
    chk("out", out, m_out);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    if (busy === 1'b1) busy_n++;
    if (done === 1'b1) begin done_n++; done_gap = cyc - done_cyc; done_cyc = cyc; end
    if (!r || !e) rx_t = -1;
    else if (rx_t < 0) begin
      if (out === 1'b0) begin rx_t = 0; fall_cyc = cyc; end
    end else begin
      rx_t++;
      if (rx_t % OS == OS / 2) begin
        if (rx_t / OS >= 1 && rx_t / OS <= 8) rx_b[rx_t/OS-1] = out;
        if (rx_t / OS == 9) begin rxq.push_back(rx_b); rx_t = -1; end
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) step(1, 1, 0, 8'h00);
  endtask

  task automatic clr();
    rxq.delete(); sent.delete();
    busy_n = 0; done_n = 0;
  endtask

  initial begin
    vec_t tbl[7];
    int push_cyc, k;
    tbl = '{
      '{0, 1, 1, 8'h11, 0, 1, 0, 0},
      '{1, 0, 1, 8'h22, 0, 1, 0, 0},
      '{1, 1, 0, 8'h33, 1, 1, 0, 0},
      '{1, 1, 1, 8'h5A, 1, 1, 0, 0},
      '{1, 1, 0, 8'h44, 1, 0, 1, 0},
      '{1, 0, 0, 8'h55, 0, 1, 0, 0},
      '{1, 1, 0, 8'h66, 1, 1, 0, 0}
    };
    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].d);
      chk("tbl_ready", ready_s, tbl[i].x_ready);
      chk("tbl_out", out, tbl[i].x_out);
      chk("tbl_busy", busy, tbl[i].x_busy);
      chk("tbl_done", done, tbl[i].x_done);
    end
    idle(4);

    clr();
    step(1, 1, 1, 8'hA5);
    push_cyc = cyc;
    idle(170);
    chk_n("t1_latency", fall_cyc - push_cyc, 1);
    chk_n("t1_done_at", done_cyc - fall_cyc, 10 * OS);
    chk_n("t1_busy_len", busy_n, 10 * OS);
    chk_n("t1_dones", done_n, 1);
    chk_n("t1_frames", rxq.size(), 1);
    chk_n("t1_byte", rxq.size() > 0 ? int'(rxq[0]) : -1, 8'hA5);

    clr();
    step(1, 1, 1, 8'h00);
    step(1, 1, 1, 8'hFF);
    idle(340);
    chk_n("t2_done_gap", done_gap, 10 * OS);
    chk_n("t2_busy_len", busy_n, 20 * OS);
    chk_n("t2_frames", rxq.size(), 2);
    chk_n("t2_byte0", rxq.size() > 0 ? int'(rxq[0]) : -1, 8'h00);
    chk_n("t2_byte1", rxq.size() > 1 ? int'(rxq[1]) : -1, 8'hFF);

    clr();
    for (int i = 1; i <= 6; i++) step(1, 1, 1, 8'(i));
    chk("t3_ready_full", ready_s, 1'b0);
    idle(5 * 10 * OS + 20);
    chk_n("t3_frames", rxq.size(), 5);
    for (int i = 0; i < 5; i++) chk_n("t3_order", rxq.size() > i ? int'(rxq[i]) : -1, i + 1);

    clr();
    step(1, 1, 1, 8'h3C);
    step(1, 1, 1, 8'h11);
    step(1, 1, 1, 8'h22);
    idle(48);
    step(1, 0, 0, 8'h00);
    chk("t4_out", out, 1'b1);
    chk("t4_busy", busy, 1'b0);
    idle(400);
    chk_n("t4_dones", done_n, 0);
    chk_n("t4_frames", rxq.size(), 0);
    step(1, 1, 1, 8'h81);
    idle(170);
    chk_n("t4_refr", rxq.size(), 1);
    chk_n("t4_byte", rxq.size() > 0 ? int'(rxq[0]) : -1, 8'h81);

    clr();
    step(1, 1, 1, 8'h96);
    step(1, 1, 1, 8'h69);
    idle(88);
    step(0, 1, 0, 8'h00);
    chk("t5_out", out, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    step(1, 1, 0, 8'h00);
    chk("t5_ready", ready_s, 1'b1);
    idle(400);
    chk_n("t5_frames", rxq.size(), 0);
    chk_n("t5_dones", done_n, 0);

    clr();
    k = 0;
    while (sent.size() < 104 && k < 30000) begin
      byte unsigned b;
      b = (sent.size() == 0) ? 8'h00 : (sent.size() == 1) ? 8'h55 :
          (sent.size() == 2) ? 8'hAA : (sent.size() == 3) ? 8'hFF : 8'($urandom);
      step(1, 1, $urandom_range(0, 3) == 0, b);
      k++;
    end
    idle(6 * 10 * OS);
    chk_n("t6_frames", rxq.size(), sent.size());
    chk_n("t6_dones", done_n, sent.size());
    for (int i = 0; i < sent.size(); i++)
      chk_n("t6_byte", rxq.size() > i ? int'(rxq[i]) : -1, int'(sent[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
